// File: rtl/data_memory_sized.sv
// data_memory_sized: synchronous byte-lane data memory for the MEM stage.
// Byte/halfword/word loads and stores with lane steering and sign/zero
// extension, a registered read with a ReadValid strobe, misalignment
// detection, and a power-up clear sequence that holds Ready low until every
// word has been written to zero.
// Optional feature: define DMEM_BOUNDS_CHECK_EN to reject word indices
// >= DEPTH with RangeErr; otherwise the index wraps modulo DEPTH.
module data_memory_sized #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              ReadValid,
    output logic              Ready,
    output logic              MisalignErr,
    output logic              RangeErr
);
    localparam int B     = DATA_W / 8;
    localparam int OFF_W = $clog2(B);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               read_valid_q, read_valid_d;
    logic               misalign_err_q, misalign_err_d;
    logic               range_err_q, range_err_d;
    logic [OFF_W-1:0]   rd_off_q, rd_off_d;
    logic [1:0]         rd_size_q, rd_size_d;
    logic               rd_uns_q, rd_uns_d;
    logic               rd_zero_q, rd_zero_d;

    logic [OFF_W-1:0]   off;
    logic [IDX_W-1:0]   idx;
    logic               idle;
    logic               misalign;
    logic               out_of_range;
    logic               wr_en;
    logic               rd_en;
    logic [B-1:0]       lane_we;
    logic [IDX_W-1:0]   mem_idx;
    logic [DATA_W-1:0]  wr_data;
    logic [DATA_W-1:0]  rd_word;
    logic [DATA_W-1:0]  rd_sel;

    assign off  = Address[OFF_W-1:0];
    assign idx  = Address[OFF_W +: IDX_W];
    assign idle = (state_q == ST_IDLE);

`ifdef DMEM_BOUNDS_CHECK_EN
    // Any set bit above the word index means the word lies beyond DEPTH.
    assign out_of_range = |Address[ADDR_W-1:OFF_W+IDX_W];
`else
    // Upper address bits are ignored, so the index wraps modulo DEPTH.
    logic unused_upper;
    assign unused_upper = ^Address[ADDR_W-1:OFF_W+IDX_W];
    assign out_of_range = 1'b0;
`endif

    // Alignment rules: halfwords on even bytes, words on word boundaries, size 11 reserved.
    always_comb begin
        misalign = 1'b0;
        case (Size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = off[0];
            2'b10:   misalign = (off != '0);
            default: misalign = 1'b1;
        endcase
    end

    // Init/idle sequencing: sweep cnt across every word, then accept requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    // Request decode: a store wins over a simultaneous load; errors suppress both.
    always_comb begin
        wr_en          = !rst && idle && MemWrite && !misalign && !out_of_range;
        rd_en          = !rst && idle && MemRead && !MemWrite && !misalign && !out_of_range;
        read_valid_d   = rd_en;
        misalign_err_d = idle && (MemRead || MemWrite) && misalign;
        range_err_d    = idle && (MemRead || MemWrite) && out_of_range;
        rd_off_d       = rd_en ? off      : rd_off_q;
        rd_size_d      = rd_en ? Size     : rd_size_q;
        rd_uns_d       = rd_en ? Unsigned : rd_uns_q;
        rd_zero_d      = rd_en ? 1'b0     : rd_zero_q;
    end

    // Write port steering: the clear sweep writes whole words of zero, stores hit selected lanes.
    always_comb begin
        lane_we = '0;
        mem_idx = idx;
        wr_data = WriteData << {off, 3'b000};
        if (state_q == ST_INIT) begin
            lane_we = '1;
            mem_idx = cnt_q;
            wr_data = '0;
        end else if (wr_en) begin
            case (Size)
                2'b00:   lane_we = B'(1) << off;
                2'b01:   lane_we = B'(3) << off;
                default: lane_we = '1;
            endcase
        end
    end

    // Control and strobe registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_INIT;
            cnt_q          <= '0;
            read_valid_q   <= 1'b0;
            misalign_err_q <= 1'b0;
            range_err_q    <= 1'b0;
            rd_off_q       <= '0;
            rd_size_q      <= 2'b10;
            rd_uns_q       <= 1'b0;
            rd_zero_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            read_valid_q   <= read_valid_d;
            misalign_err_q <= misalign_err_d;
            range_err_q    <= range_err_d;
            rd_off_q       <= rd_off_d;
            rd_size_q      <= rd_size_d;
            rd_uns_q       <= rd_uns_d;
            rd_zero_q      <= rd_zero_d;
        end
    end

    // One 8-bit RAM per byte lane so each lane has its own write enable.
    genvar gi;
    generate
        for (gi = 0; gi < B; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_lane_q;

            // Lane write and registered lane read.
            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    mem[mem_idx] <= wr_data[gi*8 +: 8];
                end
                if (rd_en) begin
                    rd_lane_q <= mem[idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_lane_q;
        end
    endgenerate

    // Extract the loaded lane from the registered word and extend it.
    always_comb begin
        rd_sel   = rd_word >> {rd_off_q, 3'b000};
        ReadData = rd_word;
        case (rd_size_q)
            2'b00:   ReadData = {{(DATA_W-8){~rd_uns_q & rd_sel[7]}}, rd_sel[7:0]};
            2'b01:   ReadData = {{(DATA_W-16){~rd_uns_q & rd_sel[15]}}, rd_sel[15:0]};
            default: ReadData = rd_word;
        endcase
        if (rd_zero_q) begin
            ReadData = '0;
        end
    end

    assign ReadValid   = read_valid_q;
    assign MisalignErr = misalign_err_q;
    assign RangeErr    = range_err_q;
    assign Ready       = idle;
endmodule
